data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Two-port arbiter and sequencer for the single-port 256x16 data RAM (sync write, async read, word index = byte address bits [8:1]).
- Shares the RAM between the CPU load/store path (port A) and a DMA/debug loader (port B) using round-robin grant.
- Registers read data, returns a one-cycle ack per access and flags illegal addresses, so neither requester drives RAM control pins directly.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, byte address width
- MEM_BYTES, 512, legal byte address space (256 words x 2 bytes); legal iff addr < MEM_BYTES and addr[0]==0

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  port A request, held until a_ack
- a_we  in  1  port A 1=write, 0=read
- a_addr  in  ADDR_W  port A byte address
- a_wdata  in  DATA_W  port A write data
- a_rdata  out  DATA_W  port A registered read data
- a_ack  out  1  port A one-cycle completion pulse
- b_req, b_we, b_addr, b_wdata, b_rdata, b_ack  same as port A, for port B
- err  out  1  pulses with ack when the served access was illegal
- busy  out  1  high in SERVE and ACK
- mem_access_addr  out  ADDR_W  to RAM
- mem_write_data  out  DATA_W  to RAM
- mem_write_en  out  1  to RAM
- mem_read  out  1  to RAM
- mem_read_data  in  DATA_W  from RAM (combinational)

Behaviour:
- FSM: IDLE -> SERVE -> ACK -> IDLE. Arbitration happens only in IDLE.
- IDLE:
  - If any req is high, latch winner id, we, addr and wdata into internal registers, then go to SERVE.
  - Otherwise stay in IDLE.
- Round robin:
  - last_grant register, reset value B, so A wins the first contention.
  - On contention, grant the port that is not last_grant.
  - A lone requester always wins.
  - last_grant updates on every grant.
- SERVE (exactly one cycle):
  - Drive mem_access_addr from the latched address.
  - Legal write: mem_write_en=1, mem_write_data=latched wdata, mem_read=0. RAM commits on the edge leaving SERVE.
  - Legal read: mem_read=1. Capture mem_read_data into the winner's rdata register on the edge leaving SERVE.
  - Illegal access: mem_write_en=0, mem_read=0. Capture 0 into the winner's rdata. Set the err flag.
- ACK (one cycle):
  - Winner's ack=1. err=1 if the flag is set.
  - The other port's ack stays 0, and its rdata holds its previous value.
- RAM control outputs:
  - Outside SERVE: mem_write_en=0, mem_read=0, mem_access_addr=0, mem_write_data=0.
  - These outputs decode from state only, so reset forces them low asynchronously.
- Latency: req sampled high at edge N, SERVE in cycle N+1, ack high in cycle N+2. One access every 3 cycles maximum.
- Requester protocol:
  - Address, data and we may change after the granting edge; the block uses only latched values.
  - A req still high in the cycle after ack (IDLE) is a new request.
  - Request changes during SERVE or ACK are ignored until IDLE.
- rdata is held until overwritten by that port's next read. A write leaves rdata unchanged. Ack on a write still pulses.
- Reset (asynchronous, any state):
  - state=IDLE, last_grant=B.
  - a_ack=b_ack=err=busy=0, a_rdata=b_rdata=0, latched registers = 0.
  - A write in SERVE when reset asserts is aborted: mem_write_en drops before the next edge.
  - No ack is issued for an aborted access.
- Simultaneous events:
  - A and B both high in IDLE: resolved by round robin.
  - The losing request stays pending and is served in the next IDLE if still high.

Test Plan:
- Port A write 0x00A4 to addr 0x0010, then read 0x0010 -> mem_write_en high exactly in SERVE. Read a_ack two cycles after req with a_rdata=0x00A4. err=0, b_ack never high.
- A and B both request continuously from reset -> grant order A,B,A,B. Acks alternate every 3 cycles and no port waits more than 6 cycles.
- Port B read addr 0x0011 (misaligned) -> mem_read=0, b_ack with err=1, b_rdata=0x0000.
- Port A write addr 0x0200 (out of range) -> mem_write_en never asserts, RAM word 0 unchanged, a_ack with err=1.
- Assert rst mid-SERVE of an A write to 0x0020 -> mem_write_en drops immediately, no a_ack. Subsequent read of 0x0020 returns the old value. FSM is in IDLE.
- Port B alone issues 4 back-to-back reads (req held) -> b_ack every 3rd cycle. last_grant=B, then an A request wins on the next IDLE.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one 256x16 data RAM between the CPU
// load/store path (A) and the DMA/debug loader (B); one access per 3 cycles.
module data_mem_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_BYTES = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, SERVE, ACK} state_t;

  // One extra bit so a limit equal to the full address space still compares correctly.
  localparam logic [ADDR_W:0] MEM_LIMIT = MEM_BYTES[ADDR_W:0];

  state_t            state_q, state_d;
  logic              last_b_q, last_b_d;
  logic              gnt_b_q, gnt_b_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic              addr_legal;
  logic              grant_b;
  logic [DATA_W-1:0] capture_data;

  assign addr_legal = ({1'b0, addr_q} < MEM_LIMIT) && !addr_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;
      gnt_b_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      gnt_b_q   <= gnt_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    last_b_d        = last_b_q;
    gnt_b_d         = gnt_b_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    err_d           = err_q;
    a_rdata_d       = a_rdata_q;
    b_rdata_d       = b_rdata_q;
    grant_b         = 1'b0;
    capture_data    = '0;
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          // B wins when alone, or on contention when A was granted last.
          grant_b  = b_req && (!a_req || !last_b_q);
          gnt_b_d  = grant_b;
          last_b_d = grant_b;
          we_d     = grant_b ? b_we    : a_we;
          addr_d   = grant_b ? b_addr  : a_addr;
          wdata_d  = grant_b ? b_wdata : a_wdata;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        mem_access_addr = addr_q;
        mem_write_en    = addr_legal && we_q;
        mem_read        = addr_legal && !we_q;
        mem_write_data  = (addr_legal && we_q) ? wdata_q : '0;
        err_d           = !addr_legal;
        // Legal writes keep rdata; legal reads load RAM data; illegal accesses clear it.
        if (!we_q || !addr_legal) begin
          capture_data = addr_legal ? mem_read_data : '0;
          if (gnt_b_q) b_rdata_d = capture_data;
          else         a_rdata_d = capture_data;
        end
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign a_ack   = (state_q == ACK) && !gnt_b_q;
  assign b_ack   = (state_q == ACK) && gnt_b_q;
  assign err     = (state_q == ACK) && err_q;
  assign busy    = (state_q != IDLE);
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule
